// File: rtl/phase_report_seq.sv
// Phase-result frame sequencer: snapshots four channel captures, derives offsets
// relative to channel 1 and streams a fixed 20-byte frame over a valid/ready byte link.
module phase_report_seq #(
  parameter logic [7:0] P_SYNC = 8'hA5,
  parameter int         P_W    = 29
) (
  input  logic           i_clk,
  input  logic           i_res_n,
  input  logic           i_ph_en,
  input  logic [P_W-1:0] i_ph1,
  input  logic [P_W-1:0] i_ph2,
  input  logic [P_W-1:0] i_ph3,
  input  logic [P_W-1:0] i_ph4,
  output logic [7:0]     o_tx_data,
  output logic           o_tx_valid,
  input  logic           i_tx_ready,
  output logic           o_busy,
  output logic           o_overrun,
  output logic [7:0]     o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t         state;
  logic [P_W-1:0] snap [4];
  logic [P_W-1:0] prev [4];
  logic [7:0]     frame [1:19];
  logic [4:0]     idx;

  logic [P_W-1:0] diff  [3];
  logic [31:0]    words [4];
  logic [3:0]     stale;
  logic [7:0]     nxt   [20];
  logic [7:0]     chk;

  // Frame image computed from the snapshots; the subtraction wraps naturally at P_W bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stale[i] = (snap[i] == prev[i]);
    end
    words[0] = {{(32-P_W){1'b0}}, snap[0]};
    for (int i = 0; i < 3; i++) begin
      diff[i]      = snap[i+1] - snap[0];
      words[i+1]   = {{(32-P_W){diff[i][P_W-1]}}, diff[i]};
    end
    nxt[0] = P_SYNC;
    nxt[1] = o_frame_cnt;
    nxt[2] = {4'b0000, stale};
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < 4; b++) begin
        nxt[3 + 4*n + b] = words[n][8*(3-b) +: 8];
      end
    end
    chk = 8'h00;
    for (int k = 1; k < 19; k++) begin
      chk = chk ^ nxt[k];
    end
    nxt[19] = chk;
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state       <= IDLE;
      idx         <= 5'd0;
      o_tx_data   <= 8'h00;
      o_tx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_cnt <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        snap[i] <= '0;
        prev[i] <= '0;
      end
      for (int k = 1; k < 20; k++) begin
        frame[k] <= 8'h00;
      end
    end else begin
      // Any strobe outside IDLE is dropped and reported one cycle later.
      o_overrun <= i_ph_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_ph_en) begin
            snap[0] <= i_ph1;
            snap[1] <= i_ph2;
            snap[2] <= i_ph3;
            snap[3] <= i_ph4;
            o_busy  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          for (int k = 1; k < 20; k++) begin
            frame[k] <= nxt[k];
          end
          for (int i = 0; i < 4; i++) begin
            prev[i] <= snap[i];
          end
          idx        <= 5'd0;
          o_tx_data  <= nxt[0];
          o_tx_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (o_tx_valid && i_tx_ready) begin
            if (idx == 5'd19) begin
              o_tx_valid  <= 1'b0;
              o_tx_data   <= 8'h00;
              o_busy      <= 1'b0;
              o_frame_cnt <= o_frame_cnt + 8'd1;
              state       <= IDLE;
            end else begin
              idx       <= idx + 5'd1;
              o_tx_data <= frame[idx + 5'd1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
